// File: rtl/ofm_wr_pkg.sv
// Shared state type and sizing helpers for the OFM tile write controller.
package ofm_wr_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int MAX_PE = 256;

  function automatic int wpt_of(input int pe, input int data_w, input int word_w);
    return (pe * data_w) / word_w;
  endfunction

  function automatic logic [15:0] ceil_div(input logic [15:0] num, input logic [15:0] den);
    logic [16:0] sum;
    sum = {1'b0, num} + {1'b0, den} - 17'd1;
    return 16'(sum / {1'b0, den});
  endfunction

  // Lanes 0..n-1 enabled; n==0 means the channel count fills the tile exactly.
  function automatic logic [MAX_PE-1:0] lane_mask(input logic [15:0] n);
    logic [MAX_PE-1:0] m;
    for (int i = 0; i < MAX_PE; i++) m[i] = (n == 16'd0) || (i < int'(n));
    return m;
  endfunction

endpackage

// File: rtl/ofm_addr_gen.sv
// Column/row/tile counters with an incremental HWC-tiled word address; advances one beat per accept.
// Address and last-beat flags describe the beat currently offered for acceptance.
module ofm_addr_gen #(
  parameter int ADDR_W = 32,
  parameter int WPT    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              accept,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] pix_stride,
  input  logic [15:0]       cfg_w,
  input  logic [15:0]       cfg_h,
  input  logic [15:0]       num_tiles,
  output logic [ADDR_W-1:0] addr,
  output logic              last_tile,
  output logic              last_beat
);

  localparam logic [ADDR_W-1:0] WPT_A = ADDR_W'(WPT);

  logic [15:0]       col;
  logic [15:0]       row;
  logic [15:0]       tile;
  logic [ADDR_W-1:0] tile_base;
  logic              end_col;
  logic              end_row;

  assign end_col   = (col == cfg_w - 16'd1);
  assign end_row   = (row == cfg_h - 16'd1);
  assign last_tile = (tile == num_tiles - 16'd1);
  assign last_beat = last_tile && end_row && end_col;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      tile      <= '0;
      tile_base <= '0;
      addr      <= '0;
    end else if (init) begin
      col       <= '0;
      row       <= '0;
      tile      <= '0;
      tile_base <= base_addr;
      addr      <= base_addr;
    end else if (accept) begin
      if (end_col) begin
        col <= '0;
        if (end_row) begin
          // Next channel tile restarts at pixel 0, offset by one tile's words.
          row       <= '0;
          tile      <= tile + 16'd1;
          tile_base <= tile_base + WPT_A;
          addr      <= tile_base + WPT_A;
        end else begin
          row  <= row + 16'd1;
          addr <= addr + pix_stride;
        end
      end else begin
        col  <= col + 16'd1;
        addr <= addr + pix_stride;
      end
    end
  end

endmodule

// File: rtl/ofm_tile_write_ctrl.sv
// OFM store controller: tile-major PE beats in, HWC-tiled SRAM writes out, one-cycle output register.
// Optional OFM_WR_RELU_EN zeroes negative lanes before the register; in_ready stalls only while a write is pending.
module ofm_tile_write_ctrl
  import ofm_wr_pkg::*;
#(
  parameter int PE     = 16,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [15:0]          ofm_c,
  input  logic [15:0]          ofm_w,
  input  logic [15:0]          ofm_h,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic                 in_valid,
  input  logic [PE*DATA_W-1:0] in_data,
  output logic                 in_ready,
  input  logic                 mem_ready,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [PE*DATA_W-1:0] wr_data,
  output logic [PE-1:0]        wr_strb,
  output logic                 busy,
  output logic                 done
);

  localparam int                WPT    = wpt_of(PE, DATA_W, WORD_W);
  localparam int                BEAT_W = PE * DATA_W;
  localparam logic [ADDR_W-1:0] WPT_A  = ADDR_W'(WPT);

  state_t            state;
  logic [15:0]       cfg_w;
  logic [15:0]       cfg_h;
  logic [15:0]       num_tiles;
  logic [ADDR_W-1:0] pix_stride;
  logic [PE-1:0]     strb_last;
  logic [15:0]       tiles_in;
  logic              launch;
  logic              zero_dim;
  logic              accept;
  logic              last_tile;
  logic              last_beat;
  logic [ADDR_W-1:0] beat_addr;
  logic [BEAT_W-1:0] beat_data;

  assign tiles_in = ceil_div(ofm_c, 16'(PE));
  assign launch   = (state == IDLE) && start;
  assign zero_dim = (ofm_c == 16'd0) || (ofm_w == 16'd0) || (ofm_h == 16'd0);
  assign in_ready = (state == RUN) && (!wr_en || mem_ready);
  assign accept   = in_valid && in_ready;

`ifdef OFM_WR_RELU_EN
  always_comb begin
    beat_data = in_data;
    for (int i = 0; i < PE; i++) begin
      if (in_data[i*DATA_W + DATA_W - 1]) beat_data[i*DATA_W +: DATA_W] = '0;
    end
  end
`else
  assign beat_data = in_data;
`endif

  ofm_addr_gen #(
    .ADDR_W (ADDR_W),
    .WPT    (WPT)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .init       (launch),
    .accept     (accept),
    .base_addr  (base_addr),
    .pix_stride (pix_stride),
    .cfg_w      (cfg_w),
    .cfg_h      (cfg_h),
    .num_tiles  (num_tiles),
    .addr       (beat_addr),
    .last_tile  (last_tile),
    .last_beat  (last_beat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_w      <= '0;
      cfg_h      <= '0;
      num_tiles  <= '0;
      pix_stride <= '0;
      strb_last  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cfg_w      <= ofm_w;
            cfg_h      <= ofm_h;
            num_tiles  <= tiles_in;
            pix_stride <= ADDR_W'(tiles_in) * WPT_A;
            strb_last  <= PE'(lane_mask(ofm_c % 16'(PE)));
            busy       <= 1'b1;
            if (zero_dim) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (accept && last_beat) state <= DRAIN;
        end
        DRAIN: begin
          // The final write is taken once nothing is pending at the next edge.
          if (!wr_en || mem_ready) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_strb <= '0;
    end else if (accept) begin
      wr_en   <= 1'b1;
      wr_addr <= beat_addr;
      wr_data <= beat_data;
      wr_strb <= last_tile ? strb_last : '1;
    end else if (mem_ready) begin
      wr_en <= 1'b0;
    end
  end

endmodule

// File: doc/ofm_tile_write_ctrl.md
Name: ofm_tile_write_ctrl

Overview:
- Parametrised successor of the MobileNet block output-store controller.
- Accepts PE-lane OFM beats from the compute array in tile-major order: channel tile outer, then row, then column. Writes them to OFM SRAM in channel-interleaved (HWC-tiled) layout.
- Adds over the previous generation: separate height, arbitrary base address, ceil tiling with a partial-tile byte strobe, valid/ready backpressure on both sides, and a done pulse.

Parameters:
- PE, 16, lanes per beat.
- DATA_W, 8, bits per lane.
- ADDR_W, 32, word-address width.
- WORD_W, 32, SRAM word width; WPT = PE*DATA_W/WORD_W words per tile (4 at defaults). PE*DATA_W must be a multiple of WORD_W.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  launch pulse; sampled only in IDLE.
- ofm_c  in  16  output channels.
- ofm_w  in  16  output width.
- ofm_h  in  16  output height.
- base_addr  in  ADDR_W  first word address.
- in_valid  in  1  beat valid.
- in_data  in  PE*DATA_W  beat; lane 0 in LSBs.
- in_ready  out  1  beat accepted when in_valid&&in_ready.
- mem_ready  in  1  SRAM accepts the current write.
- wr_en  out  1  write request.
- wr_addr  out  ADDR_W  word address of the beat's first word.
- wr_data  out  PE*DATA_W  data.
- wr_strb  out  PE  per-lane byte enable.
- busy  out  1  high from launch until done.
- done  out  1  one-cycle pulse.

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0; all counters 0. Reset mid-frame discards the frame with no further writes.
- Config is latched on an accepted start; later changes to the inputs are ignored until the next launch.
- num_tiles = ceil(ofm_c/PE), 16 bit.
- pix_stride = num_tiles*WPT, computed at launch, ADDR_W bits.
- rem = ofm_c mod PE.
- Counters: col 0..W-1, row 0..H-1, tile 0..num_tiles-1.
- Address for each beat: base_addr + (row*W+col)*pix_stride + tile*WPT, modulo 2^ADDR_W.
  - Maintained incrementally: cur += pix_stride per beat.
  - At the end of a tile: tile_base += WPT; cur = tile_base.
  - No multipliers in the per-beat path.
- FSM:
  - IDLE: start → RUN. If any of ofm_c, ofm_w, ofm_h is 0, go to DONE instead (no writes).
  - RUN: advance counters on each accepted beat. The beat with tile=num_tiles-1, row=H-1, col=W-1 → DRAIN.
  - DRAIN: wait until !wr_en (final write taken) → DONE.
  - DONE: done=1 for one cycle → IDLE.
- start outside IDLE is ignored.
- busy=1 in RUN, DRAIN and DONE.
- Output register, latency 1:
  - On an accepted beat, next cycle wr_en=1 and wr_addr/wr_data/wr_strb are loaded.
  - They hold stable while wr_en && !mem_ready.
  - wr_en clears on mem_ready when no new beat is accepted that cycle.
- in_ready = (state==RUN) && (!wr_en || mem_ready). This allows a full-throughput beat every cycle and a new load in the same cycle the old write completes.
- wr_strb is all ones, except in the last tile when rem≠0, where only lanes 0..rem-1 are set.
- wr_data is the in_data beat unmodified, including masked lanes.
- W=1 and/or H=1 are legal; the end-of-row and end-of-tile wraps happen on the same beat.
- Maximum 65535 per dimension; no counter overflow inside that range.

Optional Feature:
- Macro OFM_WR_RELU_EN.
- Defined: each lane of in_data is treated as signed DATA_W, and negative lanes are written as 0. Applied combinationally before the output register, so latency is unchanged.
- Undefined: data passes through unmodified.

Decomposition:
- Package ofm_wr_pkg holds:
  - state enum typedef (IDLE, RUN, DRAIN, DONE);
  - the WPT derivation function;
  - ceil_div function;
  - lane-mask generation function.
- One sub-module, ofm_addr_gen: the counters plus the incremental address and last-beat flag, advanced by an accept strobe.
- The top module holds the FSM, handshake, output register and the optional ReLU.

Test Plan:
- C=32, W=H=2, base=0x100, mem_ready=1, continuous valid → 8 writes.
  - Addresses 0x100,0x108,0x110,0x118, then 0x104,0x10C,0x114,0x11C.
  - strb=0xFFFF throughout; done pulses one cycle after the last wr_en.
- C=20, W=H=1, base=0 → 2 writes at addr 0 (strb 0xFFFF) and addr 4 (strb 0x000F).
- C=16, W=3, H=1; mem_ready toggled 1,0,0,1,...
  - wr_* remain stable while stalled; in_ready is low only while wr_en && !mem_ready.
  - 3 writes complete in order at addresses 0, 4, 8.
- ofm_w=0 with start → done pulse in the cycle after leaving IDLE; wr_en never asserts.
- Assert rst after 3 of 8 beats in the C=32, W=H=2 frame (base=0x100).
  - All outputs 0 immediately.
  - A new start with base=0x200 restarts the frame at 0x200.
- With OFM_WR_RELU_EN defined: lanes 0x80, 0xFF, 0x7F, 0x00 → written as 0x00, 0x00, 0x7F, 0x00.
